box_pixel_shader: RTL and testbench
===================================

// Module: box_pixel_shader
// PURPOSE
//   Downstream consumer of the box colour-index stage. Turns the two 5-bit box colour indices
//   into per-pixel RGB444 for the VGA scan-out path. Paints box1/box2 rectangles, shaded border,
//   over a background pixel.
//   Indices and box positions are latched only at frame start, so a colour swap never tears mid-frame.
// PARAMETERS
//   COORD_W     10   width of pixel and box coordinates
//   BOX_W       64   box width in pixels
//   BOX_H       32   box height in pixels
//   EDGE_W      2    border thickness in pixels, drawn at half brightness
//   NUM_COLORS  18   valid palette entries, indices 0..NUM_COLORS-1
// PORTS
//   clk_machine     in   1        system clock (25 MHz pixel clock)
//   rst_machine     in   1        asynchronous reset, active-high
//   i_color_index1  in   5        box1 colour index from upstream colour stage
//   i_color_index2  in   5        box2 colour index from upstream colour stage
//   i_box1_x/_y     in   COORD_W  box1 top-left corner
//   i_box2_x/_y     in   COORD_W  box2 top-left corner
//   i_frame_start   in   1        1-cycle pulse at start of vertical blank
//   i_pix_valid     in   1        current x/y is an active pixel
//   i_x, i_y        in   COORD_W  current pixel coordinate
//   i_bg_rgb        in   12       background colour for this pixel
//   o_rgb           out  12       shaded pixel colour, RGB444 {R,G,B}
//   o_rgb_valid     out  1        o_rgb is valid; delayed copy of i_pix_valid
//   o_in_box1       out  1        pixel lies inside box1 (after priority)
//   o_in_box2       out  1        pixel lies inside box2 (after priority)
// BEHAVIOUR
// - Reset (async, clk-independent):
//   - shadow idx1=17, idx2=0; shadow box positions=0.
//   - Both pipeline stages cleared; o_rgb=0, o_rgb_valid=0, o_in_box1=0, o_in_box2=0.
// - Shadow registers: on the rising edge where i_frame_start=1, capture both indices and all
//   four coordinates. Otherwise hold.
//   - A pixel presented in the same cycle as i_frame_start uses the OLD shadow values.
// - Palette: fixed 18-entry RGB444 ROM inside the block (entry 0=12'hF00 ... entry 17=12'h888).
//   - Index >= NUM_COLORS maps to error colour 12'hF0F.
// - Hit test, done in COORD_W+1 bits so there is no wrap:
//   - inside = (x >= bx) && (x <= bx+BOX_W-1) && (y >= by) && (y <= by+BOX_H-1).
//   - A box that extends past 2^COORD_W-1 is clipped, never wrapped to x/y=0.
//   - edge = inside && (x < bx+EDGE_W || x > bx+BOX_W-1-EDGE_W || same for y).
// - Priority: box1 over box2. When both hit, o_in_box1=1 and o_in_box2=0.
// - Pipeline, fixed latency 2 cycles, no stalls, every cycle independent:
//   - S1 registers pix_valid, bg, hit/edge flags and both palette lookups.
//   - S2 selects the colour: box1 colour, else box2 colour, else bg.
//     - On an edge pixel each 4-bit channel is shifted right by 1.
//     - S2 registers the outputs.
// - o_rgb_valid = i_pix_valid delayed 2 cycles.
//   - When the delayed valid is 0: o_rgb=0 and o_in_box*=0 (blanking).
// - Upstream index values between frame starts are ignored; there is no handshake.
// - Reset asserted mid-frame: pipeline flushed immediately; shadow values return to reset values.
// TESTING
//   1 reset, then frame_start with idx1=3/idx2=5, box1 at (100,200), pixel (120,210) valid
//     -> 2 cycles later o_rgb=palette[3], o_in_box1=1, o_rgb_valid=1.
//   2 pixel (100,200), box1 corner, EDGE_W=2 -> o_rgb=palette[3]>>1 per channel.
//     Pixel (99,200) -> o_rgb=i_bg_rgb, o_in_box1=0.
//   3 idx1 changed to 7 mid-frame, no frame_start -> pixels still palette[3].
//     After the next frame_start pulse -> palette[7].
//   4 box1 and box2 both at (50,50), pixel (60,60) -> box1 colour, o_in_box1=1, o_in_box2=0.
//   5 idx2=20 latched -> box2 interior pixel = 12'hF0F.
//     Box at x=1000, pixel x=5 -> background (no wrap).
//   6 continuous valid stream, reset pulsed mid-stream -> outputs 0 at once.
//     Shadow idx1=17/idx2=0, first valid output 2 cycles after the first post-reset valid pixel.

Source files
------------

// File: rtl/box_pixel_shader.sv
// box_pixel_shader: paints two coloured boxes with a half-brightness border
// over a background pixel stream. Box positions and colour indices are
// shadowed at frame start, so changes never tear mid-frame. The pipeline has
// a fixed 2-cycle latency and never stalls.
module box_pixel_shader #(
    parameter int COORD_W    = 10,
    parameter int BOX_W      = 64,
    parameter int BOX_H      = 32,
    parameter int EDGE_W     = 2,
    parameter int NUM_COLORS = 18
) (
    input  logic               clk_machine,
    input  logic               rst_machine,
    input  logic [4:0]         i_color_index1,
    input  logic [4:0]         i_color_index2,
    input  logic [COORD_W-1:0] i_box1_x,
    input  logic [COORD_W-1:0] i_box1_y,
    input  logic [COORD_W-1:0] i_box2_x,
    input  logic [COORD_W-1:0] i_box2_y,
    input  logic               i_frame_start,
    input  logic               i_pix_valid,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [11:0]        i_bg_rgb,
    output logic [11:0]        o_rgb,
    output logic               o_rgb_valid,
    output logic               o_in_box1,
    output logic               o_in_box2
);

    // Box extents as offsets from the top-left corner, one bit wider than the
    // coordinates so a box hanging off the right/bottom is clipped, not wrapped.
    localparam logic [COORD_W:0] X_LAST      = (COORD_W+1)'(BOX_W - 1);
    localparam logic [COORD_W:0] Y_LAST      = (COORD_W+1)'(BOX_H - 1);
    localparam logic [COORD_W:0] EDGE_OFS    = (COORD_W+1)'(EDGE_W);
    localparam logic [COORD_W:0] X_INNER_END = (COORD_W+1)'(BOX_W - 1 - EDGE_W);
    localparam logic [COORD_W:0] Y_INNER_END = (COORD_W+1)'(BOX_H - 1 - EDGE_W);
    localparam logic [11:0]      ERR_RGB     = 12'hF0F;

    // Shadow (per-frame) configuration
    logic [4:0]         r_idx1;
    logic [4:0]         r_idx2;
    logic [COORD_W-1:0] r_box1_x;
    logic [COORD_W-1:0] r_box1_y;
    logic [COORD_W-1:0] r_box2_x;
    logic [COORD_W-1:0] r_box2_y;

    // Stage 1
    logic        r_s1_valid;
    logic [11:0] r_s1_bg;
    logic        r_s1_in1;
    logic        r_s1_in2;
    logic        r_s1_edge;
    logic [11:0] r_s1_col1;
    logic [11:0] r_s1_col2;

    logic [1:0]  w_hit1;
    logic [1:0]  w_hit2;
    logic        w_in1;
    logic        w_in2;
    logic        w_edge;
    logic [11:0] w_col1;
    logic [11:0] w_col2;
    logic [11:0] w_sel;
    logic [11:0] w_shaded;

    // Fixed RGB444 palette; anything past the last entry is the error colour.
    function automatic logic [11:0] f_palette(input logic [4:0] idx);
        logic [11:0] col;
        if (int'(idx) >= NUM_COLORS) begin
            col = ERR_RGB;
        end else begin
            case (idx)
                5'd0:    col = 12'hF00;
                5'd1:    col = 12'h0F0;
                5'd2:    col = 12'h00F;
                5'd3:    col = 12'hFF0;
                5'd4:    col = 12'h0FF;
                5'd5:    col = 12'hF80;
                5'd6:    col = 12'h8F0;
                5'd7:    col = 12'h08F;
                5'd8:    col = 12'hF08;
                5'd9:    col = 12'h80F;
                5'd10:   col = 12'h0F8;
                5'd11:   col = 12'hFFF;
                5'd12:   col = 12'h000;
                5'd13:   col = 12'h840;
                5'd14:   col = 12'h048;
                5'd15:   col = 12'h484;
                5'd16:   col = 12'hCCC;
                5'd17:   col = 12'h888;
                default: col = ERR_RGB;
            endcase
        end
        return col;
    endfunction

    // Returns {inside, on_border} for one box.
    function automatic logic [1:0] f_hit(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] bx,
        input logic [COORD_W-1:0] by
    );
        logic [COORD_W:0] xe;
        logic [COORD_W:0] ye;
        logic [COORD_W:0] bxe;
        logic [COORD_W:0] bye;
        logic             ins;
        logic             edg;
        xe  = {1'b0, x};
        ye  = {1'b0, y};
        bxe = {1'b0, bx};
        bye = {1'b0, by};
        ins = (xe >= bxe) && (xe <= bxe + X_LAST) &&
              (ye >= bye) && (ye <= bye + Y_LAST);
        edg = ins && ((xe < bxe + EDGE_OFS) || (xe > bxe + X_INNER_END) ||
                      (ye < bye + EDGE_OFS) || (ye > bye + Y_INNER_END));
        return {ins, edg};
    endfunction

    // Hit test and palette lookups against the current shadow values
    always_comb begin
        w_hit1 = f_hit(i_x, i_y, r_box1_x, r_box1_y);
        w_hit2 = f_hit(i_x, i_y, r_box2_x, r_box2_y);
        w_in1  = w_hit1[1];
        w_in2  = w_hit2[1] && !w_hit1[1];
        w_edge = w_in1 ? w_hit1[0] : (w_in2 ? w_hit2[0] : 1'b0);
        w_col1 = f_palette(r_idx1);
        w_col2 = f_palette(r_idx2);
    end

    // Stage-2 colour select and border dimming
    always_comb begin
        if (r_s1_in1) begin
            w_sel = r_s1_col1;
        end else if (r_s1_in2) begin
            w_sel = r_s1_col2;
        end else begin
            w_sel = r_s1_bg;
        end
        w_shaded = r_s1_edge ? {1'b0, w_sel[11:9], 1'b0, w_sel[7:5], 1'b0, w_sel[3:1]}
                             : w_sel;
    end

    // Shadow registers: only updated on the frame-start pulse
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            r_idx1   <= 5'd17;
            r_idx2   <= 5'd0;
            r_box1_x <= '0;
            r_box1_y <= '0;
            r_box2_x <= '0;
            r_box2_y <= '0;
        end else if (i_frame_start) begin
            r_idx1   <= i_color_index1;
            r_idx2   <= i_color_index2;
            r_box1_x <= i_box1_x;
            r_box1_y <= i_box1_y;
            r_box2_x <= i_box2_x;
            r_box2_y <= i_box2_y;
        end
    end

    // Stage 1: register flags, background and both palette colours
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            r_s1_valid <= 1'b0;
            r_s1_bg    <= '0;
            r_s1_in1   <= 1'b0;
            r_s1_in2   <= 1'b0;
            r_s1_edge  <= 1'b0;
            r_s1_col1  <= '0;
            r_s1_col2  <= '0;
        end else begin
            r_s1_valid <= i_pix_valid;
            r_s1_bg    <= i_bg_rgb;
            r_s1_in1   <= w_in1;
            r_s1_in2   <= w_in2;
            r_s1_edge  <= w_edge;
            r_s1_col1  <= w_col1;
            r_s1_col2  <= w_col2;
        end
    end

    // Stage 2: registered outputs, forced to zero during blanking
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            o_rgb       <= '0;
            o_rgb_valid <= 1'b0;
            o_in_box1   <= 1'b0;
            o_in_box2   <= 1'b0;
        end else begin
            o_rgb_valid <= r_s1_valid;
            o_rgb       <= r_s1_valid ? w_shaded : 12'h000;
            o_in_box1   <= r_s1_valid && r_s1_in1;
            o_in_box2   <= r_s1_valid && r_s1_in2;
        end
    end

endmodule

// File: tb/tb_box_pixel_shader.sv
// Directed bench for box_pixel_shader: a vector table for single-pixel
// behaviour plus hand-written sequences for shadowing, priority, clipping
// and reset.
module tb_box_pixel_shader;

    logic        clk_machine = 1'b0;
    logic        rst_machine = 1'b1;
    logic [4:0]  i_color_index1 = '0;
    logic [4:0]  i_color_index2 = '0;
    logic [9:0]  i_box1_x = '0;
    logic [9:0]  i_box1_y = '0;
    logic [9:0]  i_box2_x = '0;
    logic [9:0]  i_box2_y = '0;
    logic        i_frame_start = 1'b0;
    logic        i_pix_valid = 1'b0;
    logic [9:0]  i_x = '0;
    logic [9:0]  i_y = '0;
    logic [11:0] i_bg_rgb = '0;
    logic [11:0] o_rgb;
    logic        o_rgb_valid;
    logic        o_in_box1;
    logic        o_in_box2;

    int errors = 0;
    int checks = 0;

    box_pixel_shader dut (
        .clk_machine   (clk_machine),
        .rst_machine   (rst_machine),
        .i_color_index1(i_color_index1),
        .i_color_index2(i_color_index2),
        .i_box1_x      (i_box1_x),
        .i_box1_y      (i_box1_y),
        .i_box2_x      (i_box2_x),
        .i_box2_y      (i_box2_y),
        .i_frame_start (i_frame_start),
        .i_pix_valid   (i_pix_valid),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_bg_rgb      (i_bg_rgb),
        .o_rgb         (o_rgb),
        .o_rgb_valid   (o_rgb_valid),
        .o_in_box1     (o_in_box1),
        .o_in_box2     (o_in_box2)
    );

    always #5 clk_machine = ~clk_machine;

    typedef struct {
        string       name;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        valid;
        logic [11:0] bg;
        logic [11:0] exp_rgb;
        logic        exp_valid;
        logic        exp_in1;
        logic        exp_in2;
    } vec_t;

    vec_t vecs[13];

    task automatic check_outs(input string name, input logic [11:0] rgb, input logic vld,
                              input logic in1, input logic in2);
        checks++;
        if (o_rgb !== rgb || o_rgb_valid !== vld || o_in_box1 !== in1 || o_in_box2 !== in2) begin
            errors++;
            $display("FAIL %s: got rgb=%h valid=%b in1=%b in2=%b, want rgb=%h valid=%b in1=%b in2=%b",
                     name, o_rgb, o_rgb_valid, o_in_box1, o_in_box2, rgb, vld, in1, in2);
        end
    endtask

    task automatic frame(input logic [4:0] idx1, input logic [4:0] idx2,
                         input logic [9:0] b1x, input logic [9:0] b1y,
                         input logic [9:0] b2x, input logic [9:0] b2y);
        @(negedge clk_machine);
        i_color_index1 = idx1;
        i_color_index2 = idx2;
        i_box1_x = b1x;
        i_box1_y = b1y;
        i_box2_x = b2x;
        i_box2_y = b2y;
        i_frame_start = 1'b1;
        i_pix_valid = 1'b0;
        @(negedge clk_machine);
        i_frame_start = 1'b0;
    endtask

    // Present one pixel, then sample its result 2 edges later.
    task automatic pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic vld, input logic [11:0] bg, input logic [11:0] exp_rgb,
                         input logic exp_vld, input logic in1, input logic in2);
        @(negedge clk_machine);
        i_x = x;
        i_y = y;
        i_pix_valid = vld;
        i_bg_rgb = bg;
        @(posedge clk_machine);
        @(posedge clk_machine);
        #1;
        check_outs(name, exp_rgb, exp_vld, in1, in2);
    endtask

    initial begin
        // box1 (100,200) idx3=FF0, box2 (400,300) idx5=F80
        vecs[0]  = '{"b1_inside",      10'd120, 10'd210, 1'b1, 12'h123, 12'hFF0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{"b1_corner_edge", 10'd100, 10'd200, 1'b1, 12'h123, 12'h770, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{"b1_left_out",    10'd99,  10'd200, 1'b1, 12'h123, 12'h123, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"b1_last_pix",    10'd163, 10'd231, 1'b1, 12'hABC, 12'h770, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{"b1_right_out",   10'd164, 10'd231, 1'b1, 12'hABC, 12'hABC, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"b1_bottom_out",  10'd120, 10'd232, 1'b1, 12'h456, 12'h456, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"b1_first_inner", 10'd102, 10'd202, 1'b1, 12'h123, 12'hFF0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{"b1_left_edge2",  10'd101, 10'd215, 1'b1, 12'h123, 12'h770, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"b1_last_inner",  10'd161, 10'd229, 1'b1, 12'h123, 12'hFF0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{"b1_right_edge",  10'd162, 10'd215, 1'b1, 12'h123, 12'h770, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{"b2_inside",      10'd420, 10'd310, 1'b1, 12'h123, 12'hF80, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{"b2_edge",        10'd400, 10'd310, 1'b1, 12'h123, 12'h740, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{"blank_pixel",    10'd120, 10'd210, 1'b0, 12'h123, 12'h000, 1'b0, 1'b0, 1'b0};

        #1;
        check_outs("reset_state", 12'h000, 1'b0, 1'b0, 1'b0);
        #20;
        @(negedge clk_machine);
        rst_machine = 1'b0;

        frame(5'd3, 5'd5, 10'd100, 10'd200, 10'd400, 10'd300);
        for (int i = 0; i < 13; i++) begin
            pixel(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].valid, vecs[i].bg,
                  vecs[i].exp_rgb, vecs[i].exp_valid, vecs[i].exp_in1, vecs[i].exp_in2);
        end

        // Index change without frame start is ignored
        @(negedge clk_machine);
        i_color_index1 = 5'd7;
        pixel("no_fs_hold", 10'd120, 10'd210, 1'b1, 12'h123, 12'hFF0, 1'b1, 1'b1, 1'b0);
        frame(5'd7, 5'd5, 10'd100, 10'd200, 10'd400, 10'd300);
        pixel("after_fs_idx7", 10'd120, 10'd210, 1'b1, 12'h123, 12'h08F, 1'b1, 1'b1, 1'b0);

        // Pixel in the frame-start cycle still sees the old shadow values
        @(negedge clk_machine);
        i_color_index1 = 5'd2;
        i_box1_x = 10'd500;
        i_frame_start = 1'b1;
        i_x = 10'd120;
        i_y = 10'd210;
        i_pix_valid = 1'b1;
        @(posedge clk_machine);
        #1;
        i_frame_start = 1'b0;
        @(posedge clk_machine);
        #1;
        check_outs("fs_same_cycle_old", 12'h08F, 1'b1, 1'b1, 1'b0);
        pixel("fs_new_values", 10'd120, 10'd210, 1'b1, 12'h321, 12'h321, 1'b1, 1'b0, 1'b0);

        // Overlapping boxes: box1 wins
        frame(5'd7, 5'd5, 10'd50, 10'd50, 10'd50, 10'd50);
        pixel("priority_b1", 10'd60, 10'd60, 1'b1, 12'h123, 12'h08F, 1'b1, 1'b1, 1'b0);

        // Out-of-range index and clipping at the right border
        frame(5'd1, 5'd20, 10'd0, 10'd500, 10'd1000, 10'd0);
        pixel("err_color", 10'd1010, 10'd10, 1'b1, 12'h123, 12'hF0F, 1'b1, 1'b0, 1'b1);
        pixel("err_color_edge", 10'd1000, 10'd10, 1'b1, 12'h123, 12'h707, 1'b1, 1'b0, 1'b1);
        pixel("clip_x1023", 10'd1023, 10'd10, 1'b1, 12'h123, 12'hF0F, 1'b1, 1'b0, 1'b1);
        pixel("no_wrap_x5", 10'd5, 10'd10, 1'b1, 12'h555, 12'h555, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream: continuous valid pixel inside box1
        frame(5'd1, 5'd3, 10'd0, 10'd0, 10'd200, 10'd200);
        @(negedge clk_machine);
        i_x = 10'd10;
        i_y = 10'd10;
        i_bg_rgb = 12'h123;
        i_pix_valid = 1'b1;
        @(posedge clk_machine);
        @(posedge clk_machine);
        #1;
        check_outs("stream_pre_rst", 12'h0F0, 1'b1, 1'b1, 1'b0);
        @(negedge clk_machine);
        rst_machine = 1'b1;
        #1;
        check_outs("rst_async_clear", 12'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clk_machine);
        rst_machine = 1'b0;
        @(posedge clk_machine);
        #1;
        check_outs("post_rst_lat1", 12'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clk_machine);
        #1;
        // shadow back to idx1=17 (888) with both boxes at the origin
        check_outs("post_rst_first", 12'h888, 1'b1, 1'b1, 1'b0);
        pixel("post_rst_b1_edge", 10'd0, 10'd0, 1'b1, 12'h123, 12'h444, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
